tc_add_fold: RTL and testbench
==============================

// Module: tc_add_fold
// PURPOSE
//  Tensor-core row-reduction stage. Reduces SHAPE_N rows of SHAPE_K elements each to SHAPE_N sums.
//  Rows are time-multiplexed onto NUM_TREE fadd_tree instances over PASSES = SHAPE_N/NUM_TREE passes.
//  Sits after the multiply stage and before the writeback.
//  Unlike tc_add, it registers the control sideband with the data and applies rm_i to every tree.
//  It also presents one valid/ready transaction per matrix tile.
// PARAMETERS
//  SHAPE_N        8   rows per tile; NUM_TREE must divide it exactly (elaboration $error otherwise)
//  SHAPE_K        8   elements per row, i.e. fadd_tree input count
//  ELEMENT_WIDTH  9   bits per element and per result, in fadd_tree encoding
//  NUM_TREE       2   fadd_tree instances; PASSES = SHAPE_N/NUM_TREE, PW = max(1, clog2(PASSES))
//  CTRL_C_WIDTH   16  sideband c width
//  DEPTH_WARP     4   warp id width
// PORTS
//  clk              in   1                      clock
//  rst_n            in   1                      asynchronous active-low reset
//  r_v_i            in   SHAPE_N*SHAPE_K*EW     row r at [(r+1)*SHAPE_K*EW-1 -: SHAPE_K*EW]
//  rm_i             in   3                      rounding mode sent to all trees; latched on accept
//  ctrl_c_i         in   CTRL_C_WIDTH           sideband, latched on accept
//  ctrl_rm_i        in   3                      sideband, latched on accept
//  ctrl_reg_idxw_i  in   8                      sideband, latched on accept
//  ctrl_warpid_i    in   DEPTH_WARP             sideband, latched on accept
//  in_valid_i       in   1                      tile valid
//  in_ready_o       out  1                      tile accept
//  out_valid_o      out  1                      result valid
//  out_ready_i      in   1                      result accept
//  result_o         out  SHAPE_N*EW             sum of row r at [(r+1)*EW-1 -: EW]
//  fflags_o         out  5                      OR of fflags over all rows of the tile
//  ctrl_*_o         out  as inputs              latched sideband, stable while out_valid_o is high
// BEHAVIOUR
//  Reset: async on rst_n low. State=IDLE; all output regs 0; out_valid_o=0; in_ready_o=1.
//    Trees share rst_n. Reset mid-tile discards the tile; no partial output is produced.
//  FSM IDLE -> RUN -> OUT -> IDLE.
//   IDLE: in_ready_o=1. When in_valid_i is high:
//    - latch r_v_i, rm_i and ctrl_*_i
//    - clear fflags_o and the issue and collect counters
//    - go to RUN
//   RUN: tree in_valid = (issue_cnt < PASSES).
//    - Tree t of pass p gets row p*NUM_TREE+t.
//    - issue_cnt increments in a cycle where tree in_valid is high and every tree in_ready is high.
//    - Tree out_ready is 1 throughout RUN.
//    - In a cycle where every tree out_valid is high:
//      - write tree t's result into row collect_cnt*NUM_TREE+t
//      - OR the tree fflags into fflags_o
//      - increment collect_cnt
//    - Issue and collect can happen in the same cycle; passes may overlap in tree pipelines.
//    - When the collect for pass PASSES-1 lands, go to OUT on the next edge.
//   OUT: out_valid_o=1; result_o, fflags_o and ctrl_*_o are held stable.
//    - out_ready_i high moves the FSM to IDLE; out_valid_o drops on the next edge.
//    - in_ready_o = out_ready_i in OUT, a combinational path.
//    - Accepting a new tile while leaving OUT loads it and goes straight to RUN (zero-bubble).
//  Counters are PW+1 bits wide.
//    - issue_cnt saturates at PASSES.
//    - collect_cnt <= issue_cnt always; there is no wrap inside a tile.
//  Latency: PASSES issue cycles, plus tree latency, plus 1 cycle to OUT.
//    With no stalls this is PASSES + L_tree + 1 cycles from accept to out_valid_o.
//  Back-pressure:
//    - a stalled out_ready_i holds OUT indefinitely and accepts nothing else
//    - a tree in_ready low stalls issue only
//  NUM_TREE==SHAPE_N gives a single pass (PASSES=1).
//  in_valid_i is ignored outside IDLE and outside OUT with out_ready_i high.
// TESTING
//  T1 All elements 1.0, defaults, out_ready_i=1.
//     -> every row sum = 8.0; fflags_o=0.
//     -> out_valid_o rises PASSES+L_tree+1 cycles after accept.
//  T2 Row r elements all (r+1)*0.5.
//     -> row r sum = 4*(r+1), landing in the correct result_o slot (checks the pass/tree mapping).
//  T3 ctrl_c_i=16'hA5A5, warpid=4'h3, idxw=8'h7E, ctrl_rm=3'b010; hold out_ready_i=0 for 10 cycles.
//     -> ctrl_*_o and result_o are stable and in_ready_o=0 throughout.
//     -> one transfer happens on release.
//  T4 Back-to-back tiles with out_ready_i=1 and in_valid_i held high.
//     -> second tile is accepted in the same cycle the first is consumed.
//     -> results are not mixed.
//  T5 Row 0 overflows (e.g. max-normal values) and the other rows are normal.
//     -> fflags_o has OF|NX set, ORed once; the next tile shows cleared flags.
//  T6 Drop rst_n during RUN at pass 1.
//     -> out_valid_o=0 immediately, outputs 0, in_ready_o=1.
//     -> a fresh tile after release gives correct sums.

Source files
------------

// File: rtl/tc_add_fold.sv
// Tile row-reduction stage. Rows are time-multiplexed over NUM_TREE adder trees.
// fadd_tree uses a 1/4/(EW-5) sign/exponent/mantissa format with bias 7; exponent all-ones is inf/NaN.
module fadd_tree #(
  parameter int N  = 8,
  parameter int EW = 9
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N*EW-1:0] in_i,
  input  logic [2:0]      rm_i,
  input  logic            in_valid_i,
  output logic            in_ready_o,
  output logic            out_valid_o,
  input  logic            out_ready_i,
  output logic [EW-1:0]   result_o,
  output logic [4:0]      fflags_o
);
  localparam int EXW  = 4;
  localparam int MW   = EW - 1 - EXW;
  localparam int EMAX = (1 << EXW) - 1;
  localparam int FXW  = MW + EMAX - 1;
  localparam int SW   = FXW + $clog2(N) + 1;
  localparam logic [2:0] RM_RTZ = 3'd1, RM_RDN = 3'd2, RM_RUP = 3'd3, RM_RMM = 3'd4;

  logic                 v1_q, v2_q, en1, en2;
  logic signed [SW-1:0] sum_d, sum_q;
  logic [2:0]           spec_d, spec_q, rm_q;
  logic [EW-1:0]        el, res_d, res_q;
  logic [EXW-1:0]       ex;
  logic [FXW-1:0]       mag;
  logic [4:0]           flg_d, flg_q;

  // Every element is exact in fixed point, so the sum is exact and rounded only once.
  always_comb begin
    sum_d  = '0;
    spec_d = '0;
    el     = '0;
    ex     = '0;
    mag    = '0;
    for (int unsigned i = 0; i < N; i++) begin
      el = in_i[i*EW +: EW];
      ex = el[EW-2 -: EXW];
      if (ex == '1) begin
        if (el[MW-1:0] != '0) spec_d[2] = 1'b1;
        else if (el[EW-1])    spec_d[0] = 1'b1;
        else                  spec_d[1] = 1'b1;
      end else begin
        if (ex == '0) mag = FXW'(el[MW-1:0]);
        else          mag = FXW'({1'b1, el[MW-1:0]}) << (ex - 1'b1);
        if (el[EW-1]) sum_d = sum_d - SW'(mag);
        else          sum_d = sum_d + SW'(mag);
      end
    end
  end

  logic          neg, up, sat, carry;
  logic [SW-1:0] mag_a, kept, lost, half;
  logic [MW+1:0] mant;
  logic [MW-1:0] field;
  int            lead, shamt, exp_v;

  always_comb begin
    res_d = '0;
    flg_d = '0;
    neg   = sum_q[SW-1];
    mag_a = neg ? SW'(-sum_q) : SW'(sum_q);
    lead  = 0;
    for (int unsigned b = 0; b < SW; b++)
      if (mag_a[b]) lead = int'(b);
    exp_v = (lead >= MW) ? lead - MW + 1 : 0;
    shamt = (lead > MW) ? lead - MW : 0;
    kept  = mag_a >> shamt;
    lost  = mag_a - (kept << shamt);
    half  = (shamt == 0) ? '0 : (SW'(1) << (shamt - 1));
    case (rm_q)
      RM_RTZ:  up = 1'b0;
      RM_RDN:  up = neg && (lost != '0);
      RM_RUP:  up = !neg && (lost != '0);
      RM_RMM:  up = (lost != '0) && (lost >= half);
      default: up = (lost > half) || ((shamt != 0) && (lost == half) && kept[0]);
    endcase
    mant  = (MW+2)'(kept) + (MW+2)'(up);
    carry = mant[MW+1];
    if (carry) exp_v = exp_v + 1;
    field = carry ? '0 : mant[MW-1:0];
    sat   = (rm_q == RM_RTZ) || ((rm_q == RM_RDN) && !neg) || ((rm_q == RM_RUP) && neg);
    if (spec_q[2] || (spec_q[1] && spec_q[0])) begin
      res_d    = {1'b0, {EXW{1'b1}}, 1'b1, {(MW-1){1'b0}}};
      flg_d[4] = spec_q[1] && spec_q[0];
    end else if (spec_q[1] || spec_q[0]) begin
      res_d = {spec_q[0], {EXW{1'b1}}, {MW{1'b0}}};
    end else if (exp_v >= EMAX) begin
      flg_d = 5'b00101;
      res_d = sat ? {neg, EXW'(EMAX - 1), {MW{1'b1}}} : {neg, {EXW{1'b1}}, {MW{1'b0}}};
    end else begin
      res_d    = {neg, EXW'(exp_v), field};
      flg_d[0] = (lost != '0);
    end
  end

  assign en2         = !v2_q || out_ready_i;
  assign en1         = !v1_q || en2;
  assign in_ready_o  = en1;
  assign out_valid_o = v2_q;
  assign result_o    = res_q;
  assign fflags_o    = flg_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_q   <= 1'b0;
      v2_q   <= 1'b0;
      sum_q  <= '0;
      spec_q <= '0;
      rm_q   <= '0;
      res_q  <= '0;
      flg_q  <= '0;
    end else begin
      if (en1) begin
        v1_q <= in_valid_i;
        if (in_valid_i) begin
          sum_q  <= sum_d;
          spec_q <= spec_d;
          rm_q   <= rm_i;
        end
      end
      if (en2) begin
        v2_q <= v1_q;
        if (v1_q) begin
          res_q <= res_d;
          flg_q <= flg_d;
        end
      end
    end
  end
endmodule

module tc_add_fold #(
  parameter int SHAPE_N       = 8,
  parameter int SHAPE_K       = 8,
  parameter int ELEMENT_WIDTH = 9,
  parameter int NUM_TREE      = 2,
  parameter int CTRL_C_WIDTH  = 16,
  parameter int DEPTH_WARP    = 4
) (
  input  logic                                     clk,
  input  logic                                     rst_n,
  input  logic [SHAPE_N*SHAPE_K*ELEMENT_WIDTH-1:0] r_v_i,
  input  logic [2:0]                               rm_i,
  input  logic [CTRL_C_WIDTH-1:0]                  ctrl_c_i,
  input  logic [2:0]                               ctrl_rm_i,
  input  logic [7:0]                               ctrl_reg_idxw_i,
  input  logic [DEPTH_WARP-1:0]                    ctrl_warpid_i,
  input  logic                                     in_valid_i,
  output logic                                     in_ready_o,
  output logic                                     out_valid_o,
  input  logic                                     out_ready_i,
  output logic [SHAPE_N*ELEMENT_WIDTH-1:0]         result_o,
  output logic [4:0]                               fflags_o,
  output logic [CTRL_C_WIDTH-1:0]                  ctrl_c_o,
  output logic [2:0]                               ctrl_rm_o,
  output logic [7:0]                               ctrl_reg_idxw_o,
  output logic [DEPTH_WARP-1:0]                    ctrl_warpid_o
);
  localparam int EW     = ELEMENT_WIDTH;
  localparam int RW     = SHAPE_K * EW;
  localparam int PASSES = SHAPE_N / NUM_TREE;
  localparam int PW     = (PASSES > 1) ? $clog2(PASSES) : 1;
  localparam logic [PW:0] LAST = (PW+1)'(PASSES);

  if (SHAPE_N % NUM_TREE != 0) begin : g_shape_chk
    $error("tc_add_fold: NUM_TREE must divide SHAPE_N");
  end

  typedef enum logic [1:0] {IDLE, RUN, OUT} state_e;

  state_e                      state_q, state_d;
  logic [PW:0]                 issue_q, issue_d, collect_q, collect_d, issue_idx;
  logic [SHAPE_N*RW-1:0]       rows_q;
  logic [SHAPE_N*EW-1:0]       result_q, result_d;
  logic [4:0]                  fflags_q, fflags_d;
  logic [2:0]                  rm_q, ctrl_rm_q;
  logic [CTRL_C_WIDTH-1:0]     ctrl_c_q;
  logic [7:0]                  ctrl_idxw_q;
  logic [DEPTH_WARP-1:0]       ctrl_warpid_q;
  logic                        load, t_in_valid, t_out_ready;
  logic [NUM_TREE-1:0]         t_in_ready, t_out_valid;
  logic [NUM_TREE*EW-1:0]      t_res;
  logic [NUM_TREE*5-1:0]       t_flg;

  // Clamp keeps the row select in range once issue has saturated.
  assign issue_idx   = (issue_q < LAST) ? issue_q : '0;
  assign t_out_ready = (state_q == RUN);

  for (genvar t = 0; t < NUM_TREE; t++) begin : g_tree
    fadd_tree #(.N(SHAPE_K), .EW(EW)) u_tree (
      .clk         (clk),
      .rst_n       (rst_n),
      .in_i        (rows_q[(int'(issue_idx)*NUM_TREE + t)*RW +: RW]),
      .rm_i        (rm_q),
      .in_valid_i  (t_in_valid),
      .in_ready_o  (t_in_ready[t]),
      .out_valid_o (t_out_valid[t]),
      .out_ready_i (t_out_ready),
      .result_o    (t_res[t*EW +: EW]),
      .fflags_o    (t_flg[t*5 +: 5])
    );
  end

  always_comb begin
    state_d     = state_q;
    issue_d     = issue_q;
    collect_d   = collect_q;
    result_d    = result_q;
    fflags_d    = fflags_q;
    load        = 1'b0;
    in_ready_o  = 1'b0;
    out_valid_o = 1'b0;
    t_in_valid  = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready_o = 1'b1;
        if (in_valid_i) begin
          load    = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        t_in_valid = (issue_q < LAST);
        if (t_in_valid && (&t_in_ready)) issue_d = issue_q + 1'b1;
        if (&t_out_valid) begin
          for (int unsigned t = 0; t < NUM_TREE; t++) begin
            result_d[(int'(collect_q)*NUM_TREE + int'(t))*EW +: EW] = t_res[t*EW +: EW];
            fflags_d = fflags_d | t_flg[t*5 +: 5];
          end
          collect_d = collect_q + 1'b1;
        end
        if (collect_q == LAST) state_d = OUT;
      end
      OUT: begin
        out_valid_o = 1'b1;
        in_ready_o  = out_ready_i;
        if (out_ready_i) begin
          state_d = IDLE;
          if (in_valid_i) begin
            load    = 1'b1;
            state_d = RUN;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    if (load) begin
      issue_d   = '0;
      collect_d = '0;
      fflags_d  = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      issue_q       <= '0;
      collect_q     <= '0;
      result_q      <= '0;
      fflags_q      <= '0;
      rows_q        <= '0;
      rm_q          <= '0;
      ctrl_c_q      <= '0;
      ctrl_rm_q     <= '0;
      ctrl_idxw_q   <= '0;
      ctrl_warpid_q <= '0;
    end else begin
      state_q   <= state_d;
      issue_q   <= issue_d;
      collect_q <= collect_d;
      result_q  <= result_d;
      fflags_q  <= fflags_d;
      if (load) begin
        rows_q        <= r_v_i;
        rm_q          <= rm_i;
        ctrl_c_q      <= ctrl_c_i;
        ctrl_rm_q     <= ctrl_rm_i;
        ctrl_idxw_q   <= ctrl_reg_idxw_i;
        ctrl_warpid_q <= ctrl_warpid_i;
      end
    end
  end

  assign result_o        = result_q;
  assign fflags_o        = fflags_q;
  assign ctrl_c_o        = ctrl_c_q;
  assign ctrl_rm_o       = ctrl_rm_q;
  assign ctrl_reg_idxw_o = ctrl_idxw_q;
  assign ctrl_warpid_o   = ctrl_warpid_q;
endmodule

// File: tb/tb_tc_add_fold.sv
// Directed bench for tc_add_fold: reset, sums, row mapping, stall, back-to-back, overflow, mid-tile reset.
module tb_tc_add_fold;
  localparam int N = 8, K = 8, EW = 9, NT = 2;
  localparam int PASSES = N / NT, L_TREE = 2, LAT = PASSES + L_TREE + 1;

  logic              clk, rst_n;
  logic [N*K*EW-1:0] r_v_i;
  logic [2:0]        rm_i, ctrl_rm_i, ctrl_rm_o;
  logic [15:0]       ctrl_c_i, ctrl_c_o;
  logic [7:0]        ctrl_reg_idxw_i, ctrl_reg_idxw_o;
  logic [3:0]        ctrl_warpid_i, ctrl_warpid_o;
  logic              in_valid_i, in_ready_o, out_valid_o, out_ready_i;
  logic [N*EW-1:0]   result_o;
  logic [4:0]        fflags_o;

  tc_add_fold #(.SHAPE_N(N), .SHAPE_K(K), .ELEMENT_WIDTH(EW), .NUM_TREE(NT),
                .CTRL_C_WIDTH(16), .DEPTH_WARP(4)) dut (
    .clk(clk), .rst_n(rst_n), .r_v_i(r_v_i), .rm_i(rm_i), .ctrl_c_i(ctrl_c_i),
    .ctrl_rm_i(ctrl_rm_i), .ctrl_reg_idxw_i(ctrl_reg_idxw_i), .ctrl_warpid_i(ctrl_warpid_i),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o), .out_valid_o(out_valid_o),
    .out_ready_i(out_ready_i), .result_o(result_o), .fflags_o(fflags_o), .ctrl_c_o(ctrl_c_o),
    .ctrl_rm_o(ctrl_rm_o), .ctrl_reg_idxw_o(ctrl_reg_idxw_o), .ctrl_warpid_o(ctrl_warpid_o));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  logic [EW-1:0] el_row  [N];
  logic [EW-1:0] exp_row [N];

  function automatic logic [N*K*EW-1:0] tile_vec();
    logic [N*K*EW-1:0] v;
    v = '0;
    for (int r = 0; r < N; r++)
      for (int k = 0; k < K; k++) v[(r*K + k)*EW +: EW] = el_row[r];
    return v;
  endfunction

  function automatic logic [N*EW-1:0] res_vec();
    logic [N*EW-1:0] v;
    v = '0;
    for (int r = 0; r < N; r++) v[r*EW +: EW] = exp_row[r];
    return v;
  endfunction

  task automatic load_t1();
    for (int r = 0; r < N; r++) begin
      el_row[r]  = 9'h070;
      exp_row[r] = 9'h0A0;
    end
  endtask

  task automatic load_t2();
    el_row  = '{9'h060, 9'h070, 9'h078, 9'h080, 9'h084, 9'h088, 9'h08C, 9'h090};
    exp_row = '{9'h090, 9'h0A0, 9'h0A8, 9'h0B0, 9'h0B4, 9'h0B8, 9'h0BC, 9'h0C0};
  endtask

  task automatic send_tile();
    @(negedge clk);
    r_v_i = tile_vec();
    in_valid_i = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid_i = 1'b0;
  endtask

  // Called at the negedge following an accept; n counts edges until out_valid_o.
  task automatic wait_valid(output int n);
    n = 0;
    while (out_valid_o !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid_i = 1'b0; out_ready_i = 1'b1; r_v_i = '0; rm_i = 3'd0;
    ctrl_c_i = '0; ctrl_rm_i = '0; ctrl_reg_idxw_i = '0; ctrl_warpid_i = '0;
    #12;
    total++; if (out_valid_o !== 1'b0) begin bad++; $display("FAIL reset_out_valid got %b want 0", out_valid_o); end
    total++; if (in_ready_o !== 1'b1) begin bad++; $display("FAIL reset_in_ready got %b want 1", in_ready_o); end
    total++; if (result_o !== '0) begin bad++; $display("FAIL reset_result got %h want 0", result_o); end
    total++; if (fflags_o !== 5'b0) begin bad++; $display("FAIL reset_fflags got %b want 0", fflags_o); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_ones();
    int n;
    load_t1(); rm_i = 3'd0; out_ready_i = 1'b1;
    send_tile();
    wait_valid(n);
    total++; if (n != LAT) begin bad++; $display("FAIL t1_latency got %0d want %0d", n, LAT); end
    total++; if (result_o !== res_vec()) begin bad++; $display("FAIL t1_result got %h want %h", result_o, res_vec()); end
    total++; if (fflags_o !== 5'b0) begin bad++; $display("FAIL t1_fflags got %b want 0", fflags_o); end
    @(negedge clk);
    total++; if (out_valid_o !== 1'b0) begin bad++; $display("FAIL t1_consumed got %b want 0", out_valid_o); end
  endtask

  task automatic test_row_map();
    int n;
    load_t2(); rm_i = 3'd0; out_ready_i = 1'b1;
    send_tile();
    wait_valid(n);
    total++; if (n != LAT) begin bad++; $display("FAIL t2_latency got %0d want %0d", n, LAT); end
    total++; if (result_o !== res_vec()) begin bad++; $display("FAIL t2_result got %h want %h", result_o, res_vec()); end
    total++; if (fflags_o !== 5'b0) begin bad++; $display("FAIL t2_fflags got %b want 0", fflags_o); end
    @(negedge clk);
  endtask

  task automatic test_stall();
    int n;
    load_t2(); out_ready_i = 1'b0;
    ctrl_c_i = 16'hA5A5; ctrl_warpid_i = 4'h3; ctrl_reg_idxw_i = 8'h7E; ctrl_rm_i = 3'b010;
    send_tile();
    ctrl_c_i = 16'h0000; ctrl_warpid_i = 4'h0; ctrl_reg_idxw_i = 8'h00; ctrl_rm_i = 3'b000;
    wait_valid(n);
    total++; if (n != LAT) begin bad++; $display("FAIL t3_latency got %0d want %0d", n, LAT); end
    load_t1(); r_v_i = tile_vec(); in_valid_i = 1'b1;
    load_t2();
    for (int c = 0; c < 10; c++) begin
      total++; if (out_valid_o !== 1'b1) begin bad++; $display("FAIL t3_hold_valid cyc %0d got %b want 1", c, out_valid_o); end
      total++; if (in_ready_o !== 1'b0) begin bad++; $display("FAIL t3_in_ready cyc %0d got %b want 0", c, in_ready_o); end
      total++; if (result_o !== res_vec()) begin bad++; $display("FAIL t3_result cyc %0d got %h want %h", c, result_o, res_vec()); end
      total++; if ({ctrl_c_o, ctrl_warpid_o, ctrl_reg_idxw_o, ctrl_rm_o} !== {16'hA5A5, 4'h3, 8'h7E, 3'b010}) begin
        bad++; $display("FAIL t3_ctrl cyc %0d got %h/%h/%h/%b want a5a5/3/7e/010", c, ctrl_c_o, ctrl_warpid_o, ctrl_reg_idxw_o, ctrl_rm_o);
      end
      @(negedge clk);
    end
    in_valid_i = 1'b0; out_ready_i = 1'b1;
    @(negedge clk);
    total++; if (out_valid_o !== 1'b0) begin bad++; $display("FAIL t3_release got %b want 0", out_valid_o); end
    total++; if (in_ready_o !== 1'b1) begin bad++; $display("FAIL t3_idle_ready got %b want 1", in_ready_o); end
    @(negedge clk);
    total++; if (out_valid_o !== 1'b0) begin bad++; $display("FAIL t3_single_transfer got %b want 0", out_valid_o); end
  endtask

  task automatic test_back_to_back();
    logic [N*K*EW-1:0] tile_b;
    logic [N*EW-1:0]   exp_a, exp_b;
    int n;
    load_t2(); tile_b = tile_vec(); exp_b = res_vec();
    load_t1(); exp_a = res_vec();
    rm_i = 3'd0; out_ready_i = 1'b1;
    @(negedge clk);
    r_v_i = tile_vec(); in_valid_i = 1'b1;
    @(posedge clk);
    @(negedge clk);
    r_v_i = tile_b;
    wait_valid(n);
    total++; if (n != LAT) begin bad++; $display("FAIL t4_latency_a got %0d want %0d", n, LAT); end
    total++; if (result_o !== exp_a) begin bad++; $display("FAIL t4_result_a got %h want %h", result_o, exp_a); end
    total++; if (in_ready_o !== 1'b1) begin bad++; $display("FAIL t4_zero_bubble_ready got %b want 1", in_ready_o); end
    @(negedge clk);
    total++; if (out_valid_o !== 1'b0) begin bad++; $display("FAIL t4_out_drop got %b want 0", out_valid_o); end
    total++; if (in_ready_o !== 1'b0) begin bad++; $display("FAIL t4_run_ready got %b want 0", in_ready_o); end
    in_valid_i = 1'b0;
    wait_valid(n);
    total++; if (n != LAT) begin bad++; $display("FAIL t4_latency_b got %0d want %0d", n, LAT); end
    total++; if (result_o !== exp_b) begin bad++; $display("FAIL t4_result_b got %h want %h", result_o, exp_b); end
    @(negedge clk);
  endtask

  task automatic test_overflow();
    int n;
    load_t1(); el_row[0] = 9'h0EF; exp_row[0] = 9'h0F0;
    rm_i = 3'd0; out_ready_i = 1'b1;
    send_tile();
    wait_valid(n);
    total++; if (result_o !== res_vec()) begin bad++; $display("FAIL t5_rne_result got %h want %h", result_o, res_vec()); end
    total++; if (fflags_o !== 5'b00101) begin bad++; $display("FAIL t5_rne_fflags got %b want 00101", fflags_o); end
    @(negedge clk);
    exp_row[0] = 9'h0EF; rm_i = 3'd1;
    send_tile();
    wait_valid(n);
    total++; if (result_o !== res_vec()) begin bad++; $display("FAIL t5_rtz_result got %h want %h", result_o, res_vec()); end
    total++; if (fflags_o !== 5'b00101) begin bad++; $display("FAIL t5_rtz_fflags got %b want 00101", fflags_o); end
    @(negedge clk);
    load_t1(); rm_i = 3'd0;
    send_tile();
    wait_valid(n);
    total++; if (fflags_o !== 5'b0) begin bad++; $display("FAIL t5_flags_cleared got %b want 0", fflags_o); end
    total++; if (result_o !== res_vec()) begin bad++; $display("FAIL t5_next_result got %h want %h", result_o, res_vec()); end
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    int n;
    load_t2(); rm_i = 3'd0; out_ready_i = 1'b1; ctrl_c_i = 16'h1234;
    send_tile();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    total++; if (out_valid_o !== 1'b0) begin bad++; $display("FAIL t6_out_valid got %b want 0", out_valid_o); end
    total++; if (in_ready_o !== 1'b1) begin bad++; $display("FAIL t6_in_ready got %b want 1", in_ready_o); end
    total++; if (result_o !== '0) begin bad++; $display("FAIL t6_result got %h want 0", result_o); end
    total++; if (ctrl_c_o !== 16'h0) begin bad++; $display("FAIL t6_ctrl_c got %h want 0", ctrl_c_o); end
    @(negedge clk);
    rst_n = 1'b1;
    load_t1();
    send_tile();
    wait_valid(n);
    total++; if (n != LAT) begin bad++; $display("FAIL t6_latency got %0d want %0d", n, LAT); end
    total++; if (result_o !== res_vec()) begin bad++; $display("FAIL t6_result_after got %h want %h", result_o, res_vec()); end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_ones();
    test_row_map();
    test_stall();
    test_back_to_back();
    test_overflow();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end
endmodule
